fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, beat width.
REQ-003 SHALL have parameter MAX_BURST, default 8, maximum beats per grant (1..255).
REQ-004 SHALL have port wr_clk  input  1  write-domain clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req  input  NUM_REQ  per-requester beat valid.
REQ-007 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  flattened beat data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port req_last  input  NUM_REQ  marks last beat of a packet.
REQ-009 SHALL have port req_ack  output  NUM_REQ  one-hot beat accepted this cycle.
REQ-010 SHALL have port fifo_full  input  1  full flag from the FIFO write side.
REQ-011 SHALL have port fifo_wr_en  output  1  FIFO write strobe.
REQ-012 SHALL have port fifo_wdata  output  DATA_WIDTH  FIFO write data.
REQ-013 SHALL have port grant_id  output  $clog2(NUM_REQ)  current owner index.
REQ-014 SHALL have port busy  output  1  high in GRANT state.

Function
REQ-015 SHALL implement a two-state FSM: ARB and GRANT.
REQ-016 In ARB, when any req bit is high, SHALL latch grant_id = first index i with req[i] high, searching from rr_ptr upward modulo NUM_REQ, and enter GRANT next cycle; otherwise stay in ARB.
REQ-017 In GRANT, fifo_wr_en and req_ack[grant_id] SHALL be combinationally high iff req[grant_id]=1 and fifo_full=0; all other req_ack bits 0.
REQ-018 fifo_wdata SHALL equal req_data slice of grant_id in GRANT; 0 in ARB.
REQ-019 A beat is accepted on a rising edge where fifo_wr_en=1; the burst counter (8 bits) SHALL increment per accepted beat.
REQ-020 GRANT SHALL release (return to ARB) after an accepted beat with req_last[grant_id]=1, or after the MAX_BURST-th accepted beat.
REQ-021 GRANT SHALL release if req[grant_id]=0 for one full cycle, even with zero beats accepted.
REQ-022 fifo_full=1 SHALL stall without release; burst counter holds.
REQ-023 On release, rr_ptr SHALL become (grant_id+1) mod NUM_REQ and the burst counter SHALL clear.
REQ-024 Minimum gap between grants SHALL be one ARB cycle; req/ack latency is 1 cycle from req rising in ARB.
REQ-025 fifo_wr_en SHALL never be high in ARB or while fifo_full=1.

Reset
REQ-026 On rst, state SHALL be ARB, rr_ptr=0, grant_id=0, burst counter=0.
REQ-027 Reset SHALL take effect immediately; fifo_wr_en, req_ack, busy SHALL drop to 0 in the same cycle, a mid-burst packet being abandoned.
REQ-028 fifo_wdata SHALL be 0 during reset.

Configuration
REQ-029 Macro FIFO_WR_ARB_STATS_EN SHALL, when defined, add output beat_cnt (NUM_REQ*16 bits) holding a per-requester 16-bit wrapping count of accepted beats, cleared by rst.
REQ-030 Without FIFO_WR_ARB_STATS_EN, port beat_cnt and its counters SHALL not exist; all other behaviour identical.

Verification
REQ-031 Single requester: req[0]=1, 3 beats 0xA1,0xA2,0xA3, last on 3rd -> fifo_wr_en 3 cycles starting 1 cycle after req, data in order, then ARB.
REQ-032 Round-robin: req=4'b1111 held, each last on 1st beat -> grant order 0,1,2,3,0 with one ARB gap each.
REQ-033 Burst cap: req[2]=1 for 20 beats, no last -> release after 8 beats, regrant to 2 if sole requester, beats 9..16 follow.
REQ-034 Backpressure: fifo_full=1 for 5 cycles mid-burst -> fifo_wr_en=0, req_ack=0, burst count frozen, resumes with no lost/duplicated data.
REQ-035 Reset mid-burst: rst pulse after 2 of 4 beats -> outputs 0 immediately, grant restarts from requester 0.
REQ-036 With FIFO_WR_ARB_STATS_EN: 10 beats from req 1, 3 from req 3 -> beat_cnt slices = 0,10,0,3.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that lets NUM_REQ packet sources share one FIFO write
// port. Ownership is granted to one requester at a time and held for a
// packet, up to MAX_BURST beats, or until the owner stops requesting. The
// next search then starts from the requester after the previous owner.
//
// Build option:
//   FIFO_WR_ARB_STATS_EN  when defined, adds output beat_cnt, which holds one
//                         16-bit wrapping count of accepted beats per
//                         requester. The counts are cleared by rst.
//
// Parameters:
//   NUM_REQ     number of requesters (2..8)
//   DATA_WIDTH  beat width
//   MAX_BURST   maximum beats accepted per grant (1..255)
//
// Ports:
//   wr_clk      write-domain clock, rising edge
//   rst         asynchronous, active-high reset
//   req         per-requester beat valid
//   req_data    flattened beat data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last    per-requester last-beat-of-packet marker
//   req_ack     one-hot; the owner's beat is accepted this cycle
//   fifo_full   FIFO full flag (write side)
//   fifo_wr_en  FIFO write strobe
//   fifo_wdata  FIFO write data (0 while arbitrating or in reset)
//   grant_id    index of the current or most recent owner
//   busy        high while a grant is held
//   beat_cnt    (FIFO_WR_ARB_STATS_EN only) per-requester beat counters
//
// FSM states
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_ARB   | no owner; pick the first active requester from r_rr_ptr up
//   ST_GRANT | r_grant_id owns the write port; beats pass straight through
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8
) (
  input  logic                          wr_clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ack,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         beat_cnt
`endif
);

  localparam int GW = $clog2(NUM_REQ);
  // One extra bit so that (pointer + offset) cannot overflow before the
  // modulo fold.
  localparam int SW = GW + 1;
  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]    r_state;
  logic [GW-1:0] r_rr_ptr;
  logic [GW-1:0] r_grant_id;
  logic [7:0]    r_burst_cnt;

  logic [GW-1:0] w_pick_id;
  logic          w_any_req;
  logic          w_in_grant;
  logic          w_own_req;
  logic          w_own_last;
  logic          w_accept;
  logic          w_cap_hit;
  logic          w_release;
  logic [GW-1:0] w_next_rr;

  // -------------------------------------------------------------------------
  // Round-robin pick. The loop walks offsets from high to low, so the lowest
  // offset from r_rr_ptr that has an active request is the one kept.
  // -------------------------------------------------------------------------
  always_comb begin
    logic [SW-1:0] v_sum;
    logic [GW-1:0] v_idx;
    w_pick_id = r_rr_ptr;
    v_sum     = '0;
    v_idx     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      v_sum = {1'b0, r_rr_ptr} + SW'(k);
      if (v_sum >= SW'(NUM_REQ)) begin
        v_sum = v_sum - SW'(NUM_REQ);
      end
      v_idx = v_sum[GW-1:0];
      if (req[v_idx]) begin
        w_pick_id = v_idx;
      end
    end
  end

  assign w_any_req  = |req;
  assign w_in_grant = (r_state == ST_GRANT);
  assign w_own_req  = req[r_grant_id];
  assign w_own_last = req_last[r_grant_id];

  // The rst term makes the strobe drop in the same cycle as an asynchronous
  // reset, even before the state register has settled back to ST_ARB.
  assign w_accept   = w_in_grant & w_own_req & ~fifo_full & ~rst;

  // This is the MAX_BURST-th beat when the count before the increment is
  // MAX_BURST-1.
  assign w_cap_hit  = ((r_burst_cnt + 8'd1) == MAX_B);

  // Release on a finished packet, on the burst cap, or when the owner has
  // stopped requesting. A stall on fifo_full keeps the grant: w_own_req is
  // still high, and w_accept is low.
  assign w_release  = w_in_grant &
                      (~w_own_req | (w_accept & (w_own_last | w_cap_hit)));

  assign w_next_rr  = (r_grant_id == GW'(NUM_REQ - 1)) ? '0 : (r_grant_id + GW'(1));

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_ARB;
      r_rr_ptr    <= '0;
      r_grant_id  <= '0;
      r_burst_cnt <= '0;
    end else begin
      case (r_state)
        ST_ARB: begin
          if (w_any_req) begin
            r_grant_id  <= w_pick_id;
            r_burst_cnt <= '0;
            r_state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_rr_ptr    <= w_next_rr;
            r_burst_cnt <= '0;
            r_state     <= ST_ARB;
          end else if (w_accept) begin
            r_burst_cnt <= r_burst_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= ST_ARB;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign fifo_wr_en = w_accept;
  assign req_ack    = w_accept ? (NUM_REQ'(1) << r_grant_id) : '0;
  assign busy       = w_in_grant & ~rst;
  assign grant_id   = r_grant_id;
  assign fifo_wdata = (w_in_grant & ~rst) ?
                      req_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;

`ifdef FIFO_WR_ARB_STATS_EN
  // -------------------------------------------------------------------------
  // Per-requester accepted-beat counters. Each counter wraps at 16 bits.
  // -------------------------------------------------------------------------
  logic [NUM_REQ*16-1:0] r_beat_cnt;

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      r_beat_cnt[r_grant_id*16 +: 16] <= r_beat_cnt[r_grant_id*16 +: 16] + 16'd1;
    end
  end

  assign beat_cnt = r_beat_cnt;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Each requester is modelled as a stream of beats held in a queue. When a
// beat is queued for a requester, the same beat is also pushed into that
// requester's expected queue. A monitor samples the DUT on the falling edge.
// On every FIFO write it pops the expected queue of the owner and compares
// the data. It also checks the grant and release decisions against a
// transaction-level round-robin model, which holds only the pointer, the
// owner and a count of beats.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 8;

  logic              wr_clk = 1'b0;
  logic              rst    = 1'b1;
  logic [N-1:0]      req      = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      req_last = '0;
  logic [N-1:0]      req_ack;
  logic              fifo_full = 1'b0;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_wdata;
  logic [1:0]        grant_id;
  logic              busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [N*16-1:0]   beat_cnt;
`endif

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .wr_clk     (wr_clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ack    (req_ack),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_wdata (fifo_wdata),
    .grant_id   (grant_id),
    .busy       (busy)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .beat_cnt   (beat_cnt)
`endif
  );

  always #5 wr_clk = ~wr_clk;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string why);
    n_chk++;
    n_err++;
    $display("FAIL %s: %s (t=%0t)", name, why, $time);
  endtask

  // Stimulus streams, and a second copy of the same beats for the scoreboard.
  logic [7:0] drv_data [N][$];
  bit         drv_last [N][$];
  logic [7:0] exp_data [N][$];

  int         full_pct   = 0;
  int         pause_pct  = 0;
  bit         full_force = 1'b0;
  logic [N-1:0] acc_mask = '0;

  int grant_log[$];
  int burst_log[$];

  // Reference model state.
  int           m_rr    = 0;
  int           m_gid   = 0;
  int           m_beats = 0;
  int           m_total = 0;
  int           m_stat [N];
  bit           prev_busy = 1'b0;
  bit           prev_acc  = 1'b0;
  logic [N-1:0] prev_req  = '0;
  logic [N-1:0] prev_last = '0;

  function automatic int rr_pick(input logic [N-1:0] r, input int rr);
    for (int k = 0; k < N; k++) begin
      if (r[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  task automatic push_beat(input int r, input logic [7:0] d, input bit l);
    drv_data[r].push_back(d);
    drv_last[r].push_back(l);
    exp_data[r].push_back(d);
  endtask

  // -------------------------------------------------------------------------
  // Driver: present the head beat of each stream. Pop a beat that the
  // monitor saw accepted on the edge just taken.
  // -------------------------------------------------------------------------
  always @(posedge wr_clk) begin
    logic [7:0] tmp_d;
    bit         tmp_l;
    bit         paused;
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_mask[i] && drv_data[i].size() > 0) begin
        tmp_d = drv_data[i].pop_front();
        tmp_l = drv_last[i].pop_front();
      end
      paused = ($urandom_range(99) < pause_pct);
      if (drv_data[i].size() > 0 && !paused) begin
        req[i]               = 1'b1;
        req_data[i*DW +: DW] = drv_data[i][0];
        req_last[i]          = drv_last[i][0];
      end else begin
        req[i]               = 1'b0;
        req_data[i*DW +: DW] = 8'($urandom);
        req_last[i]          = 1'($urandom_range(1));
      end
    end
    fifo_full = full_force || ($urandom_range(99) < full_pct);
  end

  // -------------------------------------------------------------------------
  // Monitor / scoreboard
  // -------------------------------------------------------------------------
  always @(negedge wr_clk) begin
    bit rel;
    bit exp_en;
    if (rst) begin
      chk("rst_wr_en", fifo_wr_en, 0);
      chk("rst_ack", req_ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wdata", fifo_wdata, 0);
      chk("rst_grant_id", grant_id, 0);
      acc_mask  = '0;
      m_rr      = 0;
      m_gid     = 0;
      m_beats   = 0;
      prev_busy = 1'b0;
      prev_acc  = 1'b0;
      prev_req  = '0;
      prev_last = '0;
      for (int i = 0; i < N; i++) m_stat[i] = 0;
    end else begin
      if (!prev_busy) begin
        chk("arb_to_grant", busy, (prev_req != '0));
        if (busy) begin
          m_gid = rr_pick(prev_req, m_rr);
          if (m_gid < 0) m_gid = 0;
          chk("grant_id", grant_id, m_gid);
          grant_log.push_back(m_gid);
          m_beats = 0;
        end
      end else begin
        rel = !prev_req[m_gid] || (prev_acc && (prev_last[m_gid] || m_beats == MB));
        chk("release", !busy, rel);
        if (!busy) begin
          m_rr = (m_gid + 1) % N;
          burst_log.push_back(m_beats);
          m_beats = 0;
        end else begin
          chk("grant_hold", grant_id, m_gid);
        end
      end

      exp_en = busy && req[m_gid] && !fifo_full;
      chk("wr_en", fifo_wr_en, exp_en);
      chk("ack", req_ack, exp_en ? (1 << m_gid) : 0);
      if (busy) chk("wdata_sel", fifo_wdata, req_data[m_gid*DW +: DW]);
      else      chk("wdata_idle", fifo_wdata, 0);

      if (fifo_wr_en) begin
        if (exp_data[m_gid].size() == 0) fail_now("beat_data", "unexpected beat");
        else chk("beat_data", fifo_wdata, exp_data[m_gid].pop_front());
        m_beats++;
        m_total++;
        m_stat[m_gid] = (m_stat[m_gid] + 1) % 65536;
      end

      acc_mask  = fifo_wr_en ? req_ack : '0;
      prev_busy = busy;
      prev_req  = req;
      prev_last = req_last;
      prev_acc  = fifo_wr_en;
    end
  end

  // -------------------------------------------------------------------------
  // Helpers for the directed scenarios
  // -------------------------------------------------------------------------
  function automatic bit streams_empty();
    for (int i = 0; i < N; i++) if (drv_data[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    do begin
      @(negedge wr_clk);
      #1;
      t++;
    end while (!(streams_empty() && !busy) && t < 3000);
    if (t >= 3000) fail_now(name, "timeout waiting for idle");
    repeat (2) @(negedge wr_clk);
    #1;
  endtask

  task automatic wait_beats(input string name, input int n);
    int t;
    int base;
    base = m_total;
    t = 0;
    do begin
      @(negedge wr_clk);
      #1;
      t++;
    end while (m_total - base < n && t < 500);
    if (t >= 500) fail_now(name, "timeout waiting for beats");
  endtask

  task automatic chk_log(input string name, input int q[$], input int e[$]);
    chk({name, "_len"}, q.size(), e.size());
    for (int i = 0; i < e.size() && i < q.size(); i++) chk(name, q[i], e[i]);
  endtask

  task automatic chk_drained(input string name);
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += exp_data[i].size();
    chk(name, s, 0);
  endtask

  task automatic do_reset();
    @(posedge wr_clk);
    #3 rst = 1'b1;
    repeat (2) @(posedge wr_clk);
    #3 rst = 1'b0;
    grant_log.delete();
    burst_log.delete();
  endtask

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    int eq[$];
    int r;
    int len;
    repeat (2) @(posedge wr_clk);
    #3 rst = 1'b0;
    grant_log.delete();
    burst_log.delete();

    // Single requester, three beats.
    push_beat(0, 8'hA1, 1'b0);
    push_beat(0, 8'hA2, 1'b0);
    push_beat(0, 8'hA3, 1'b1);
    wait_idle("single_req");
    eq = '{0};
    chk_log("single_grants", grant_log, eq);
    eq = '{3};
    chk_log("single_burst", burst_log, eq);

    // Round-robin with every requester active, one-beat packets.
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) push_beat(i, 8'(i * 16 + k), 1'b1);
    wait_idle("round_robin");
    eq = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk_log("rr_order", grant_log, eq);

    // Burst cap: 20 beats with no last marker.
    do_reset();
    for (int k = 1; k <= 20; k++) push_beat(2, 8'(k), 1'b0);
    wait_idle("burst_cap");
    eq = '{2, 2, 2};
    chk_log("cap_grants", grant_log, eq);
    eq = '{8, 8, 4};
    chk_log("cap_bursts", burst_log, eq);

    // Backpressure in the middle of a burst.
    do_reset();
    for (int k = 1; k <= 10; k++) push_beat(0, 8'(8'h40 + k), (k == 10));
    wait_beats("bp_start", 3);
    full_force = 1'b1;
    repeat (5) @(posedge wr_clk);
    #2 full_force = 1'b0;
    wait_idle("backpressure");
    eq = '{8, 2};
    chk_log("bp_bursts", burst_log, eq);

    // Reset in the middle of a burst. The rest of the packet is offered again.
    do_reset();
    for (int k = 1; k <= 4; k++) push_beat(0, 8'(8'hC0 + k), (k == 4));
    push_beat(1, 8'hD1, 1'b1);
    wait_beats("mid_rst_start", 2);
    @(posedge wr_clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_wr_en", fifo_wr_en, 0);
    chk("mid_rst_ack", req_ack, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wdata", fifo_wdata, 0);
    repeat (2) @(posedge wr_clk);
    #3 rst = 1'b0;
    wait_idle("mid_rst");
    eq = '{0, 0, 1};
    chk_log("mid_rst_grants", grant_log, eq);
    chk_drained("mid_rst_drain");

`ifdef FIFO_WR_ARB_STATS_EN
    do_reset();
    for (int k = 0; k < 10; k++) push_beat(1, 8'(k), (k == 9));
    for (int k = 0; k < 3; k++) push_beat(3, 8'(k), (k == 2));
    wait_idle("stats");
    chk("stats_0", beat_cnt[0*16 +: 16], 0);
    chk("stats_1", beat_cnt[1*16 +: 16], 10);
    chk("stats_2", beat_cnt[2*16 +: 16], 0);
    chk("stats_3", beat_cnt[3*16 +: 16], 3);
`endif

    // Random traffic with backpressure and requester pauses.
    do_reset();
    full_pct  = 20;
    pause_pct = 5;
    for (int it = 0; it < 300; it++) begin
      r   = $urandom_range(N - 1);
      len = $urandom_range(12, 1);
      if (drv_data[r].size() < 30) begin
        for (int k = 0; k < len; k++)
          push_beat(r, 8'($urandom), (k == len - 1) && ($urandom_range(9) != 0));
      end
      repeat ($urandom_range(8)) @(negedge wr_clk);
      #1;
    end
    full_pct  = 0;
    pause_pct = 0;
    wait_idle("random");
    chk_drained("random_drain");
`ifdef FIFO_WR_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("random_stats", beat_cnt[i*16 +: 16], m_stat[i]);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
